// File: rtl/psram_cache_pkg.sv
// Shared types and sizing helpers for the PSRAM word cache.
package psram_cache_pkg;

  localparam int ADDR_W = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_REQ,
    ST_RELEASE,
    ST_RESP
  } state_t;

  function automatic int tag_w(input int lines);
    return ADDR_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/cache_data_ram.sv
// One-word-per-line data store: registered read, per-byte write enables.
// Each byte lane is its own array so the tools map it straight onto block RAM.
module cache_data_ram #(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [LINES];
    logic [7:0] lane_rd;

    always_ff @(posedge clk) begin
      if (wr_be[gi]) lane_mem[wr_idx] <= wr_data[8*gi +: 8];
      if (rd_en) lane_rd <= lane_mem[rd_idx];
    end

    assign rd_data[8*gi +: 8] = lane_rd;
  end

endmodule

// File: rtl/psram_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of qqspi.
// Read hits complete in two cycles; misses and every write use the 4-phase memory handshake.
module psram_cache
  import psram_cache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = tag_w(LINES);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic              hit_reg;
  logic              flush_pend_reg;
  logic [LINES-1:0]  valid_reg;

  logic [TAG_W-1:0]  tag_mem [LINES];
  logic [TAG_W-1:0]  tag_rd;
  logic [31:0]       line_rd;

  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic              is_write;
  logic              lookup_hit;
  logic              flush_now;

  logic              accept;
  logic              clear_all;
  logic              fill;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic              cpu_ready_next;
  logic              mem_valid_next;
  logic [31:0]       cpu_rdata_next;
  logic [31:0]       hits_next;
  logic [31:0]       misses_next;

  assign cur_idx    = addr_reg[IDX_W-1:0];
  assign cur_tag    = addr_reg[ADDR_W-1:IDX_W];
  assign is_write   = |wstrb_reg;
  assign lookup_hit = valid_reg[cur_idx] && (tag_rd == cur_tag);
  assign flush_now  = flush | flush_pend_reg;

  cache_data_ram #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_data_ram (
    .clk     (clk),
    .rd_en   (accept),
    .rd_idx  (cpu_addr[IDX_W-1:0]),
    .rd_data (line_rd),
    .wr_be   (ram_be),
    .wr_idx  (cur_idx),
    .wr_data (ram_wdata)
  );

  // Tag store is read alongside the data RAM so both are ready in LOOKUP.
  always_ff @(posedge clk) begin
    if (fill) tag_mem[cur_idx] <= cur_tag;
    if (accept) tag_rd <= tag_mem[cpu_addr[IDX_W-1:0]];
  end

  always_comb begin
    state_next     = state_reg;
    cpu_ready_next = 1'b0;
    cpu_rdata_next = cpu_rdata;
    mem_valid_next = mem_valid;
    hits_next      = stat_hits;
    misses_next    = stat_misses;
    accept         = 1'b0;
    clear_all      = 1'b0;
    fill           = 1'b0;
    ram_be         = 4'b0000;
    ram_wdata      = mem_rdata;

    case (state_reg)
      ST_IDLE: begin
        if (flush_now) begin
          clear_all = 1'b1;
        end else if (cpu_valid) begin
          accept     = 1'b1;
          state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!is_write && lookup_hit) begin
          cpu_rdata_next = line_rd;
          cpu_ready_next = 1'b1;
          hits_next      = stat_hits + 32'd1;
          state_next     = ST_RESP;
        end else begin
          if (!is_write) misses_next = stat_misses + 32'd1;
          mem_valid_next = 1'b1;
          state_next     = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        if (mem_ready) begin
          mem_valid_next = 1'b0;
          cpu_ready_next = 1'b1;
          state_next     = ST_RELEASE;
          if (!is_write) begin
            fill           = 1'b1;
            ram_be         = 4'b1111;
            cpu_rdata_next = mem_rdata;
          end else if (hit_reg) begin
            ram_be    = wstrb_reg;
            ram_wdata = wdata_reg;
          end
        end
      end
      // Hold off new requests until qqspi has completed the 4-phase return.
      ST_RELEASE: begin
        if (!mem_ready) state_next = ST_IDLE;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      hit_reg        <= 1'b0;
      flush_pend_reg <= 1'b0;
      valid_reg      <= '0;
      cpu_ready      <= 1'b0;
      cpu_rdata      <= '0;
      mem_valid      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      stat_hits      <= '0;
      stat_misses    <= '0;
    end else begin
      state_reg   <= state_next;
      cpu_ready   <= cpu_ready_next;
      cpu_rdata   <= cpu_rdata_next;
      mem_valid   <= mem_valid_next;
      stat_hits   <= hits_next;
      stat_misses <= misses_next;

      // A line filled while a flush is pending is cleared on the next IDLE cycle.
      flush_pend_reg <= clear_all ? 1'b0 : (flush_pend_reg | flush);
      if (clear_all) valid_reg <= '0;
      else if (fill) valid_reg[cur_idx] <= 1'b1;

      if (accept) begin
        addr_reg  <= cpu_addr;
        wdata_reg <= cpu_wdata;
        wstrb_reg <= cpu_wstrb;
      end

      if (state_reg == ST_LOOKUP) begin
        hit_reg   <= lookup_hit;
        mem_addr  <= addr_reg;
        mem_wdata <= wdata_reg;
        mem_wstrb <= wstrb_reg;
      end
    end
  end

endmodule

// File: tb/tb_psram_cache.sv
// Bench for psram_cache: qqspi-style memory responder plus a line/tag reference model.
`timescale 1ns/1ps
module tb_psram_cache;
  import psram_cache_pkg::*;

  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_valid;
  logic [22:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        mem_valid;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;

  always #5 clk = ~clk;

  psram_cache #(.LINES(LINES)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cpu_valid   (cpu_valid),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Backing store seen by the responder, and the bench's own view of memory.
  logic [31:0] phys_mem [int];
  logic [31:0] ref_mem  [int];

  function automatic logic [31:0] default_word(input logic [22:0] a);
    return {a[7:0], 1'b1, a} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [31:0] phys_read(input logic [22:0] a);
    return phys_mem.exists(int'(a)) ? phys_mem[int'(a)] : default_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [22:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : default_word(a);
  endfunction

  int          lat_cfg   = 1;
  int          hold_cfg  = 0;
  int          req_count = 0;
  int          proto_bad = 0;
  logic [22:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;

  // qqspi stand-in: ready after lat_cfg cycles, kept high hold_cfg cycles past the drop of mem_valid.
  initial begin
    int          phase;
    int          cnt;
    logic        prev_valid;
    logic [31:0] w;
    phase = 0; cnt = 0; prev_valid = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        phase = 0; mem_ready = 1'b0; prev_valid = 1'b0;
      end else begin
        if (mem_valid && !prev_valid) begin
          req_count++;
          req_addr  = mem_addr;
          req_wdata = mem_wdata;
          req_wstrb = mem_wstrb;
          if (mem_ready) proto_bad++;
        end
        prev_valid = mem_valid;
        case (phase)
          0: if (mem_valid) begin cnt = lat_cfg; phase = 1; end
          1: begin
            if (cnt == 0) begin
              if (mem_wstrb == 4'b0000) begin
                mem_rdata = phys_read(mem_addr);
              end else begin
                w = phys_read(mem_addr);
                for (int b = 0; b < 4; b++)
                  if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                phys_mem[int'(mem_addr)] = w;
              end
              mem_ready = 1'b1;
              phase = 2;
            end else begin
              cnt--;
            end
          end
          2: if (!mem_valid) begin cnt = hold_cfg; phase = 3; end
          default: begin
            if (cnt == 0) begin mem_ready = 1'b0; phase = 0; end
            else cnt--;
          end
        endcase
      end
    end
  end

  // Reference cache: which tag each line holds, nothing about the RTL's internals.
  bit m_valid [LINES];
  int m_tag   [LINES];
  bit m_flush_pend;
  int exp_hits;
  int exp_misses;

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin m_valid[i] = 1'b0; m_tag[i] = 0; end
    m_flush_pend = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic wait_idle();
    do begin @(negedge clk); #1; end while (mem_ready);
    @(negedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic do_txn(input logic [22:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input bit flush_req, input bit flush_mem, input bit quick,
                        output logic [31:0] rd);
    int          idx, tg, extra, mv_cyc, rdy_cyc, cnt0;
    bit          hit, is_rd, flushed, got;
    logic [31:0] exp_d, w;
    if (!quick) wait_idle();
    if (m_flush_pend || flush_req) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_flush_pend = 1'b0;
    end
    extra = flush_req ? 1 : 0;
    idx   = int'(a) % LINES;
    tg    = int'(a) / LINES;
    is_rd = (ws == 4'b0000);
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    exp_d = ref_read(a);
    if (is_rd) begin
      if (hit) exp_hits++;
      else exp_misses++;
    end
    cnt0 = req_count;
    cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws; flush = flush_req;
    mv_cyc = 0; rdy_cyc = 0; got = 1'b0; flushed = 1'b0; rd = '0;
    for (int cyc = 1; cyc <= 200 && !got; cyc++) begin
      @(negedge clk); #1;
      flush = 1'b0;
      if (mem_valid && mv_cyc == 0) mv_cyc = cyc;
      if (flush_mem && mem_valid && !flushed) begin flush = 1'b1; flushed = 1'b1; end
      if (cpu_ready) begin
        got = 1'b1;
        rdy_cyc = cyc;
        rd = cpu_rdata;
        chk("stat_hits", stat_hits, 32'(exp_hits));
        chk("stat_misses", stat_misses, 32'(exp_misses));
      end
    end
    cpu_valid = 1'b0;
    flush = 1'b0;
    chk("ready_seen", 32'(got), 32'd1);
    @(negedge clk); #1;
    chk("ready_single_pulse", 32'(cpu_ready), 32'd0);
    if (is_rd) chk("rdata", rd, exp_d);
    if (is_rd && hit) begin
      if (!quick) chk("hit_latency", 32'(rdy_cyc), 32'(2 + extra));
      chk("hit_no_mem_req", 32'(req_count), 32'(cnt0));
    end else begin
      if (!quick) chk("mem_valid_latency", 32'(mv_cyc), 32'(2 + extra));
      chk("mem_req_count", 32'(req_count), 32'(cnt0 + 1));
      chk("mem_addr", 32'(req_addr), 32'(a));
      chk("mem_wstrb", 32'(req_wstrb), 32'(ws));
      if (!is_rd) chk("mem_wdata", req_wdata, wd);
    end
    $display("txn addr=%06h wstrb=%b flush=%0d/%0d hit=%0d rdata=%08h ready_cyc=%0d memv_cyc=%0d",
             a, ws, flush_req, flushed, hit, rd, rdy_cyc, mv_cyc);
    if (is_rd && !hit) begin m_valid[idx] = 1'b1; m_tag[idx] = tg; end
    if (!is_rd) begin
      w = exp_d;
      for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[int'(a)] = w;
    end
    if (flushed) m_flush_pend = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    bit          seen;
    resetn = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; flush = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("reset_cpu_rdata", cpu_rdata, 32'd0);
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("reset_stat_hits", stat_hits, 32'd0);
    chk("reset_stat_misses", stat_misses, 32'd0);
    resetn = 1'b0;

    phys_mem[16] = 32'hDEADBEEF;
    ref_mem[16]  = 32'hDEADBEEF;
    lat_cfg = 2; hold_cfg = 0;

    // Cold miss, then a hit on the same word.
    do_txn(23'h000010, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);
    chk("cold_data", rd, 32'hDEADBEEF);
    chk("cold_misses", stat_misses, 32'd1);
    do_txn(23'h000010, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);
    chk("repeat_hits", stat_hits, 32'd1);

    // Same index, different tag: evicts, then the original word misses again.
    do_txn(23'h000050, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);
    do_txn(23'h000010, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);
    chk("conflict_misses", stat_misses, 32'd3);

    // Byte-strobed write hit merges into the cached line.
    do_txn(23'h000010, 32'h0000AB00, 4'b0010, 1'b0, 1'b0, 1'b0, rd);
    do_txn(23'h000010, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);
    chk("merge_data", rd, 32'hDEADABEF);
    chk("merge_hits", stat_hits, 32'd2);

    // Write miss does not allocate.
    do_txn(23'h000123, 32'h12345678, 4'b1111, 1'b0, 1'b0, 1'b0, rd);
    do_txn(23'h000123, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);
    chk("no_alloc_data", rd, 32'h12345678);
    chk("no_alloc_misses", stat_misses, 32'd4);

    // Slow release of mem_ready, with the next request queued right behind.
    lat_cfg = 3; hold_cfg = 5;
    do_txn(23'h000077, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);
    do_txn(23'h000088, 32'hCAFEF00D, 4'b1001, 1'b0, 1'b0, 1'b0, rd);
    do_txn(23'h000089, 32'hA1B2C3D4, 4'b1111, 1'b0, 1'b0, 1'b1, rd);
    hold_cfg = 0;
    do_txn(23'h000077, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);

    // Flush while a miss is in flight, then flush together with a request.
    do_txn(23'h000200, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0, rd);
    do_txn(23'h000200, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);
    do_txn(23'h000200, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, rd);

    // Reset in the middle of a memory request.
    lat_cfg = 6;
    wait_idle();
    cpu_valid = 1'b1; cpu_addr = 23'h000333; cpu_wdata = '0; cpu_wstrb = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if (mem_valid) seen = 1'b1;
    end
    chk("rst_reached_mem_req", 32'(seen), 32'd1);
    resetn = 1'b1;
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_stat_hits", stat_hits, 32'd0);
    chk("rst_stat_misses", stat_misses, 32'd0);
    cpu_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    resetn = 1'b0;
    model_reset();
    lat_cfg = 1;
    do_txn(23'h000333, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, rd);
    chk("post_reset_misses", stat_misses, 32'd1);

    // Randomized traffic over a few conflicting indices.
    for (int n = 0; n < 120; n++) begin
      logic [22:0] a;
      logic [3:0]  ws;
      bit          fr, fm;
      lat_cfg  = int'($urandom_range(0, 4));
      hold_cfg = int'($urandom_range(0, 3));
      a  = 23'($urandom_range(0, 2) * LINES + $urandom_range(0, 7));
      ws = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      fr = ($urandom_range(0, 15) == 0);
      fm = ($urandom_range(0, 9) == 0);
      do_txn(a, $urandom, ws, fr, fm, 1'b0, rd);
    end

    chk("protocol_mem_valid_vs_ready", 32'(proto_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_cache.md
# psram_cache

Direct-mapped, write-through, no-write-allocate word cache between the CPU data/instruction bus and the `qqspi` PSRAM controller. It holds recently read 32-bit words so that repeated reads skip the multi-microsecond SPI transaction. All writes go through to memory. The cache side follows the same valid/ready bus as the CPU. The memory side drives `qqspi` using its 4-phase handshake.

## Interface
- `LINES`, default 64: number of one-word lines; power of two, 16..1024; `IDX_W = log2(LINES)`, `TAG_W = 23 - IDX_W`.
- `clk` input, 1: sole clock, rising edge.
- `resetn` input, 1: reset, asynchronous, active-high (asserted when 1).
- `cpu_valid` input, 1: request; held high until `cpu_ready`.
- `cpu_addr` input, 23: word address (8Mx32 space).
- `cpu_wdata` input, 32: write data.
- `cpu_wstrb` input, 4: byte enables; `0` = read.
- `cpu_rdata` output, 32: read data; valid while `cpu_ready`.
- `cpu_ready` output, 1: one-cycle completion pulse.
- `flush` input, 1: single-cycle pulse; invalidates all lines.
- `mem_valid` output, 1: request to `qqspi`.
- `mem_addr` output, 23; `mem_wdata` output, 32; `mem_wstrb` output, 4: forwarded request.
- `mem_rdata` input, 32; `mem_ready` input, 1: from `qqspi`; `mem_ready` stays high until `mem_valid` drops.
- `stat_hits` output, 32; `stat_misses` output, 32: free-running wrapping counters.

## Operation
- Storage: data RAM `LINES`x32 (sync read, byte write); tag RAM `LINES`x`TAG_W`; valid bits `LINES` flops.
- `idx = cpu_addr[IDX_W-1:0]`, `tag = cpu_addr[22:IDX_W]`. Hit = valid[idx] and the stored tag equals `tag`.
- States: IDLE, LOOKUP, MEM_REQ, RELEASE, RESP.
- IDLE: if a flush is pending, clear all valid bits in one cycle and stay in IDLE. Else, when `cpu_valid` is high, latch addr/wdata/wstrb, issue the RAM read, and go to LOOKUP.
- LOOKUP, read hit: `cpu_rdata` = RAM data, `stat_hits++`, go to RESP.
- LOOKUP, read miss: `stat_misses++`, go to MEM_REQ with `mem_wstrb = 0`.
- LOOKUP, write: go to MEM_REQ with `mem_wstrb = cpu_wstrb` and `mem_wdata = cpu_wdata`. Writes do not update the counters.
- MEM_REQ: `mem_valid` = 1, with address/data/strobe held stable. On `mem_ready`, drop `mem_valid` and go to RELEASE.
  - Read miss: write `mem_rdata` into the line, set its tag, set valid=1, and `cpu_rdata = mem_rdata`.
  - Write hit: merge the strobed bytes into the line.
  - Write miss: no allocation.
- RELEASE: assert `cpu_ready` for the first cycle only. Wait for `mem_ready` = 0, then go to IDLE.
- RESP: `cpu_ready` = 1 for one cycle, then go to IDLE.
- Flush:
  - A pulse arriving in any state sets a `flush_pend` flag.
  - The clear happens in IDLE before the next request is accepted.
  - A line filled by an in-flight miss is therefore also invalidated.
  - A flush and a `cpu_valid` in the same IDLE cycle: the flush is applied first, and the request is accepted the following cycle.
- Reset: all outputs 0, state IDLE, valid bits 0, counters 0, `flush_pend` 0. RAM contents are don't-care.
  - A reset during MEM_REQ abandons the transfer. `qqspi` shares `resetn`, so both restart clean.

## Timing
- Cycle N is the cycle in which `cpu_valid` is sampled in IDLE.
- Read hit: `cpu_ready` and `cpu_rdata` are asserted at N+2.
- Miss or write: `mem_valid` rises at N+2.
  - With `mem_ready` first sampled high at cycle M, `mem_valid` falls and `cpu_ready` pulses at M+1.
  - The next request is accepted no earlier than the cycle after `mem_ready` is seen low.
- `cpu_ready` is never high for two consecutive cycles.
- `mem_valid` never re-asserts while `mem_ready` = 1.
- Counters increment in the LOOKUP cycle. They wrap from 0xFFFFFFFF to 0.
- All outputs are registered.

## Structure
- Package `psram_cache_pkg`:
  - state enum;
  - `ADDR_W = 23`;
  - `tag_w(lines)` function.
- Sub-module `cache_data_ram`: `LINES`x32, synchronous read, 4-bit byte write enable, maps to iCE40 EBR. Tag RAM is a second instance or inline array.
- Valid bits, FSM and counters live in the top module.

## Test plan
- Cold read of 0x000010, with memory returning 0xDEADBEEF → one `qqspi` request with wstrb 0; `cpu_rdata` = 0xDEADBEEF; `stat_misses` = 1. A repeat read → `cpu_ready` at N+2, no `mem_valid`, `stat_hits` = 1.
- Conflict: read 0x000010, then 0x000050 (LINES=64, same index) → two misses. A re-read of 0x000010 misses again.
- Write hit: `wstrb` = 0010, `wdata` = 0x0000AB00 to the cached 0xDEADBEEF word → `mem_wstrb` = 0010 forwarded; a re-read hits and returns 0xDEADABEF. A write to an uncached address → next read misses.
- Slow memory: `mem_ready` held high 5 cycles after the drop of `mem_valid` → no new `mem_valid` until it falls; `cpu_ready` is a single pulse.
- Flush: flush pulse during MEM_REQ of a miss → the CPU gets its data; the next read of the same address misses. Flush concurrent with `cpu_valid` in IDLE → the request completes, one cycle later, as a miss.
- Reset asserted mid-MEM_REQ → `mem_valid` and `cpu_ready` are 0 immediately; counters are 0; the first read after release misses.
